// File: rtl/axis_rti_accum_ram_pkg.sv
// ---------------------------------------------------------------------------
// axis_rti_accum_ram_pkg
// Shared definitions for the RTI accumulator slice:
//   rti_state_e   : controller states (ACC / DRAIN / DUMP)
//   DRAIN_CYCLES  : cycles spent letting the RMW pipeline empty before a dump
//   SKID_DEPTH    : entries in the output skid buffer
// ---------------------------------------------------------------------------
package axis_rti_accum_ram_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2
    } rti_state_e;

    // Last accepted sample writes the RAM two cycles after its accept.
    localparam int DRAIN_CYCLES = 2;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_rti_accum_ram_rti_dp_ram.sv
// ---------------------------------------------------------------------------
// rti_dp_ram
// Dual-port synchronous RAM, 1-cycle read latency, read-first, no reset.
//   Port A (RMW port) : one read (a_en_i/a_addr_i -> a_rdata_o) and one
//                       write (a_we_i/a_waddr_i/a_wdata_i) per cycle.
//   Port B (dump port): read only (b_en_i/b_addr_i -> b_rdata_o).
// Ports:
//   clk_i                      rising-edge clock
//   a_en_i, a_addr_i           port A read enable / address
//   a_rdata_o                  port A read data (valid the cycle after a_en_i)
//   a_we_i, a_waddr_i, a_wdata_i  port A write enable / address / data
//   b_en_i, b_addr_i           port B read enable / address
//   b_rdata_o                  port B read data (valid the cycle after b_en_i)
// ---------------------------------------------------------------------------
module rti_dp_ram #(
    parameter int WIDTH      = 48,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  a_en_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    output logic [WIDTH-1:0]      a_rdata_o,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_waddr_i,
    input  logic [WIDTH-1:0]      a_wdata_i,
    input  logic                  b_en_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic [WIDTH-1:0]      b_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;

    // Reads sample the array before the same-edge write lands (read-first).
    always_ff @(posedge clk_i) begin
        if (a_en_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
        if (a_we_i) begin
            mem_q[a_waddr_i] <= a_wdata_i;
        end
        if (b_en_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/axis_rti_accum_ram.sv
// ---------------------------------------------------------------------------
// axis_rti_accum_ram
// Coherently integrates FMCW range bins over cfg_sweeps sweeps with a
// read-modify-write pipeline (with hazard forwarding) into a dual-port RAM,
// then streams the integrated profile out on AXI-Stream.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   cfg_nbins            bins per sweep (1..DEPTH), stable while busy
//   cfg_sweeps           sweeps per integration (0 behaves as 1)
//   s_axis_*             input samples in bin order, tlast ends a sweep
//   m_axis_*             integrated bins 0..cfg_nbins-1, tlast on the last
//   busy                 high while draining or dumping
//   dbg_state_o          current controller state (rti_state_e encoding)
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; the source holds tdata/tlast stable while tvalid is high and
// tready is low, and tvalid never depends on tready.
// ---------------------------------------------------------------------------
module axis_rti_accum_ram
    import axis_rti_accum_ram_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH:0]   cfg_nbins,
    input  logic [CNT_WIDTH-1:0]  cfg_sweeps,
    input  logic [IN_WIDTH-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [ACC_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);

    localparam int BW = ADDR_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Controller state and counters
    // -----------------------------------------------------------------------
    rti_state_e            state_q, state_d;
    logic [BW-1:0]         bin_q, bin_d;
    logic [CNT_WIDTH-1:0]  sweep_q, sweep_d;
    logic [1:0]            drain_cnt_q, drain_cnt_d;

    logic [CNT_WIDTH-1:0]  sweeps_eff;
    logic [CNT_WIDTH-1:0]  sweep_inc;
    logic                  accept;
    logic                  in_range;
    logic                  issue_a;
    logic                  dump_done;

    assign sweeps_eff    = (cfg_sweeps == '0) ? CNT_WIDTH'(1) : cfg_sweeps;
    assign sweep_inc     = sweep_q + CNT_WIDTH'(1);
    assign s_axis_tready = (state_q == ST_ACC);
    assign busy          = (state_q != ST_ACC);
    assign dbg_state_o   = state_q;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign in_range      = (bin_q < cfg_nbins);
    // Out-of-range accepts are consumed but never touch the RAM.
    assign issue_a       = accept & in_range;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        sweep_d     = sweep_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        bin_d   = '0;
                        sweep_d = sweep_inc;
                        if (sweep_inc == sweeps_eff) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = '0;
                        end
                    end else if (in_range) begin
                        // Stops at cfg_nbins so the counter never wraps back
                        // into valid addresses on an over-long sweep.
                        bin_d = bin_q + BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (dump_done) begin
                    state_d = ST_ACC;
                    sweep_d = '0;
                    bin_d   = '0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_ACC;
            bin_q       <= '0;
            sweep_q     <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            sweep_q     <= sweep_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // RMW pipeline: S0 issues the read, S1 sees RAM data and forms the sum,
    // S2 writes it. wb_* remembers the write that landed on the previous
    // edge, which a read issued on that same edge did not observe.
    // -----------------------------------------------------------------------
    logic                  s1_vld_q, s1_first_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [IN_WIDTH-1:0]   s1_x_q;
    logic                  s2_vld_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic [ACC_WIDTH-1:0]  s2_sum_q;
    logic                  wb_vld_q;
    logic [ADDR_WIDTH-1:0] wb_addr_q;
    logic [ACC_WIDTH-1:0]  wb_sum_q;

    logic [ACC_WIDTH-1:0]  ram_a_rdata;
    logic [ACC_WIDTH-1:0]  s1_base;
    logic [ACC_WIDTH:0]    s1_x_ext;
    logic [ACC_WIDTH:0]    s1_sum_wide;
    logic [ACC_WIDTH-1:0]  s1_sum;

    always_comb begin
        // Newest in-flight value wins: S2 holds a younger sum than wb.
        s1_base = ram_a_rdata;
        if (s2_vld_q && (s2_addr_q == s1_addr_q)) begin
            s1_base = s2_sum_q;
        end else if (wb_vld_q && (wb_addr_q == s1_addr_q)) begin
            s1_base = wb_sum_q;
        end

        s1_x_ext    = {{(ACC_WIDTH + 1 - IN_WIDTH){s1_x_q[IN_WIDTH-1]}}, s1_x_q};
        s1_sum_wide = {s1_base[ACC_WIDTH-1], s1_base} + s1_x_ext;

        // Overflow when the guard bit disagrees with the result sign bit.
        if (s1_sum_wide[ACC_WIDTH] != s1_sum_wide[ACC_WIDTH-1]) begin
            s1_sum = s1_sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            s1_sum = s1_sum_wide[ACC_WIDTH-1:0];
        end

        // First sweep overwrites whatever the RAM held before.
        if (s1_first_q) begin
            s1_sum = s1_x_ext[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_x_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_sum_q   <= '0;
            wb_vld_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_sum_q   <= '0;
        end else begin
            s1_vld_q   <= issue_a;
            s1_first_q <= (sweep_q == '0);
            s1_addr_q  <= bin_q[ADDR_WIDTH-1:0];
            s1_x_q     <= s_axis_tdata;
            s2_vld_q   <= s1_vld_q;
            s2_addr_q  <= s1_addr_q;
            s2_sum_q   <= s1_sum;
            wb_vld_q   <= s2_vld_q;
            wb_addr_q  <= s2_addr_q;
            wb_sum_q   <= s2_sum_q;
        end
    end

    // -----------------------------------------------------------------------
    // Dump path: port B reads in bin order into a 2-entry skid buffer. A
    // read is issued only when the buffer plus the read in flight leave a
    // free slot, so the RAM output is always captured the cycle it arrives.
    // -----------------------------------------------------------------------
    logic [BW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  rd_pend_q;
    logic                  rd_last_pend_q;
    logic [ACC_WIDTH-1:0]  ent_data_q [SKID_DEPTH];
    logic                  ent_last_q [SKID_DEPTH];
    logic                  wr_idx_q, rd_idx_q;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  issue_b;
    logic                  issue_last;
    logic [ACC_WIDTH-1:0]  ram_b_rdata;

    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = ent_data_q[rd_idx_q];
    assign m_axis_tlast  = ent_last_q[rd_idx_q] & m_axis_tvalid;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = rd_pend_q;
    assign dump_done     = pop & m_axis_tlast;
    assign occ           = cnt_q + {1'b0, rd_pend_q};
    assign issue_b       = (state_q == ST_DUMP) && (rd_ptr_q < cfg_nbins) &&
                           ((occ < 2'd2) || (pop && (occ == 2'd2)));
    assign issue_last    = (rd_ptr_q == (cfg_nbins - BW'(1)));

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (issue_b) begin
            rd_ptr_d = rd_ptr_q + BW'(1);
        end
        if (dump_done) begin
            rd_ptr_d = '0;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_last_pend_q <= 1'b0;
            wr_idx_q       <= 1'b0;
            rd_idx_q       <= 1'b0;
            cnt_q          <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                ent_data_q[i] <= '0;
                ent_last_q[i] <= 1'b0;
            end
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            rd_pend_q      <= issue_b;
            rd_last_pend_q <= issue_b & issue_last;
            cnt_q          <= cnt_d;
            if (push) begin
                ent_data_q[wr_idx_q] <= ram_b_rdata;
                ent_last_q[wr_idx_q] <= rd_last_pend_q;
                wr_idx_q             <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
        end
    end

    rti_dp_ram #(
        .WIDTH      (ACC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (aclk),
        .a_en_i    (issue_a),
        .a_addr_i  (bin_q[ADDR_WIDTH-1:0]),
        .a_rdata_o (ram_a_rdata),
        .a_we_i    (s2_vld_q),
        .a_waddr_i (s2_addr_q),
        .a_wdata_i (s2_sum_q),
        .b_en_i    (issue_b),
        .b_addr_i  (rd_ptr_q[ADDR_WIDTH-1:0]),
        .b_rdata_o (ram_b_rdata)
    );

endmodule

// File: tb/tb_axis_rti_accum_ram.sv
module tb_axis_rti_accum_ram;
    import axis_rti_accum_ram_pkg::*;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // ---------------- main DUT (48-bit accumulator) ----------------
    logic [6:0]  cfg_nbins = 7'd4;
    logic [15:0] cfg_sweeps = 16'd1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        busy;
    logic [1:0]  dbg_state;

    axis_rti_accum_ram #(
        .IN_WIDTH(32), .ACC_WIDTH(48), .ADDR_WIDTH(6), .CNT_WIDTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_nbins(cfg_nbins), .cfg_sweeps(cfg_sweeps),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- saturation DUT (8-bit accumulator) ----------------
    logic [2:0] cfg_nbins8 = 3'd2;
    logic [3:0] cfg_sweeps8 = 4'd2;
    logic [7:0] s8_tdata = '0;
    logic       s8_tvalid = 1'b0;
    logic       s8_tlast = 1'b0;
    logic       s8_tready;
    logic [7:0] m8_tdata;
    logic       m8_tvalid;
    logic       m8_tlast;
    logic       busy8;
    logic [1:0] dbg_state8;

    axis_rti_accum_ram #(
        .IN_WIDTH(8), .ACC_WIDTH(8), .ADDR_WIDTH(2), .CNT_WIDTH(4)
    ) dut8 (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_nbins(cfg_nbins8), .cfg_sweeps(cfg_sweeps8),
        .s_axis_tdata(s8_tdata), .s_axis_tvalid(s8_tvalid),
        .s_axis_tlast(s8_tlast), .s_axis_tready(s8_tready),
        .m_axis_tdata(m8_tdata), .m_axis_tvalid(m8_tvalid),
        .m_axis_tlast(m8_tlast), .m_axis_tready(1'b1),
        .busy(busy8), .dbg_state_o(dbg_state8)
    );

    // ---------------- scoreboards: {tlast, tdata} ----------------
    logic [48:0] exp_q[$];
    logic [8:0]  exp8_q[$];

    // m_tready is driven only here: fixed value or 30% random.
    logic rdy_fixed = 1'b1;
    logic rand_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_rdy ? ($urandom_range(0, 99) < 30) : rdy_fixed;
        end
    end

    // ---------------- monitors ----------------
    logic chk_busy = 1'b0;
    initial begin : mon_main
        logic [48:0] got;
        logic [48:0] exp;
        forever begin
            @(negedge aclk);
            if (chk_busy) begin
                chk_busy = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_after_tlast got=%b want=0", busy);
                end
            end
            if (aresetn && m_tvalid && m_tready) begin
                got = {m_tlast, m_tdata};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got=%h", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL beat got last=%b data=%0d want last=%b data=%0d",
                                 got[48], $signed(got[47:0]), exp[48], $signed(exp[47:0]));
                    end
                end
                if (m_tlast) chk_busy = 1'b1;
            end
        end
    end

    initial begin : mon_sat
        logic [8:0] got;
        logic [8:0] exp;
        forever begin
            @(negedge aclk);
            if (aresetn && m8_tvalid) begin
                got = {m8_tlast, m8_tdata};
                checks++;
                if (exp8_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat8 got=%h", got);
                end else begin
                    exp = exp8_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL sat_beat got last=%b data=%0d want last=%b data=%0d",
                                 got[8], $signed(got[7:0]), exp[8], $signed(exp[7:0]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_tdata = d;
        s_tlast = l;
        s_tvalid = 1'b1;
        while (!s_tready && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL send_timeout got tready=0 want 1");
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s8_tdata = d;
        s8_tlast = l;
        s8_tvalid = 1'b1;
        while (!s8_tready && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL send8_timeout got tready=0 want 1");
        end
        @(posedge aclk);
        #1;
        s8_tvalid = 1'b0;
        s8_tlast = 1'b0;
    endtask

    task automatic push_exp(input int v, input logic l);
        exp_q.push_back({l, 48'(v)});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        repeat (3) @(posedge aclk);
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL %s_done got pending=%0d busy=%b want pending=0 busy=0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", 64'(s_tready), 64'd1);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_ACC));
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: 4 bins, 3 sweeps, x=bin+1 -> 3,6,9,12
        cfg_nbins = 7'd4;
        cfg_sweeps = 16'd3;
        for (int b = 0; b < 4; b++) push_exp(3 * (b + 1), b == 3);
        for (int s = 0; s < 3; s++)
            for (int b = 0; b < 4; b++) send(32'(b + 1), b == 3);
        @(posedge aclk);
        #1;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_tready", 64'(s_tready), 64'd0);
        wait_done("t1");

        // 2: single bin, back-to-back x=5 over 4 sweeps -> 20
        cfg_nbins = 7'd1;
        cfg_sweeps = 16'd4;
        push_exp(20, 1'b1);
        for (int s = 0; s < 4; s++) send(32'd5, 1'b1);
        wait_done("t2");

        // 2b: two bins, hazard two accepts apart -> 3, 30
        cfg_nbins = 7'd2;
        cfg_sweeps = 16'd3;
        push_exp(3, 1'b0);
        push_exp(30, 1'b1);
        for (int s = 0; s < 3; s++) begin
            send(32'd1, 1'b0);
            send(32'd10, 1'b1);
        end
        wait_done("t2b");

        // 3: 8-bit accumulator saturates to 127 / -128
        exp8_q.push_back({1'b0, 8'h7f});
        exp8_q.push_back({1'b1, 8'h80});
        for (int s = 0; s < 2; s++) begin
            send8(8'd100, 1'b0);
            send8(8'h9c, 1'b1);
        end
        n = 0;
        repeat (3) @(posedge aclk);
        while ((busy8 || exp8_q.size() != 0) && n < 500) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("t3_done", 64'(exp8_q.size()), 64'd0);

        // 4: clear bins with cfg_sweeps=0 (acts as 1), then short first sweep
        cfg_nbins = 7'd4;
        cfg_sweeps = 16'd0;
        for (int b = 0; b < 4; b++) push_exp(0, b == 3);
        for (int b = 0; b < 4; b++) send(32'd0, b == 3);
        wait_done("t4clr");
        cfg_sweeps = 16'd3;
        push_exp(3, 1'b0);
        push_exp(3, 1'b0);
        push_exp(2, 1'b0);
        push_exp(2, 1'b1);
        send(32'd1, 1'b0);
        send(32'd1, 1'b1);
        for (int s = 0; s < 2; s++)
            for (int b = 0; b < 4; b++) send(32'd1, b == 3);
        wait_done("t4");

        // 5: 64 bins, 2 sweeps, random 30% tready during the dump
        cfg_nbins = 7'd64;
        cfg_sweeps = 16'd2;
        for (int b = 0; b < 64; b++) push_exp(b * 997 + 5, b == 63);
        for (int b = 0; b < 64; b++) send(32'(b * 1000 + 5), b == 63);
        rand_rdy = 1'b1;
        for (int b = 0; b < 64; b++) send(32'(-3 * b), b == 63);
        wait_done("t5");
        rand_rdy = 1'b0;

        // 6: reset during DUMP, then one sweep of 7s
        cfg_nbins = 7'd4;
        cfg_sweeps = 16'd1;
        rdy_fixed = 1'b0;
        for (int b = 0; b < 4; b++) send(32'd9, b == 3);
        n = 0;
        while (!m_tvalid && n < 100) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("t6_dump_valid", 64'(m_tvalid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_tready", 64'(s_tready), 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge aclk);
        #1;
        for (int b = 0; b < 4; b++) push_exp(7, b == 3);
        for (int b = 0; b < 4; b++) send(32'd7, b == 3);
        wait_done("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
